// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single shared memory bus.
// Optional MEM_ARBITER_RR_EN: round-robin between simultaneous requests instead of data-first priority.
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state_q, state_d;
  logic        i_pend_q, i_pend_d;
  logic        i_instr_q, i_instr_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic [31:0] i_wdata_q, i_wdata_d;
  logic [3:0]  i_wstrb_q, i_wstrb_d;
  logic        d_pend_q, d_pend_d;
  logic        d_instr_q, d_instr_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [3:0]  d_wstrb_q, d_wstrb_d;
`ifdef MEM_ARBITER_RR_EN
  logic        last_data_q, last_data_d;
`endif

  logic any_pend;
  logic grant_data;
  logic sel_data;
  logic sel_fetch;

  always_comb begin
    any_pend = i_pend_q | d_pend_q;
`ifdef MEM_ARBITER_RR_EN
    // On contention the port that was not granted last wins.
    grant_data = d_pend_q & (~i_pend_q | ~last_data_q);
`else
    grant_data = d_pend_q;
`endif

    imem_ready = (state_q == BUSY_I) & mem_ready;
    dmem_ready = (state_q == BUSY_D) & mem_ready;
    imem_rdata = imem_ready ? mem_rdata : 32'h0;
    dmem_rdata = dmem_ready ? mem_rdata : 32'h0;

    // Bus fields come straight from the pending registers, which cannot change while owned.
    mem_valid = (state_q == IDLE) & any_pend;
    sel_data  = (state_q == BUSY_D) | ((state_q == IDLE) & grant_data);
    sel_fetch = (state_q == BUSY_I) | ((state_q == IDLE) & any_pend & ~grant_data);
    mem_instr = sel_data ? d_instr_q : (sel_fetch ? i_instr_q : 1'b0);
    mem_addr  = sel_data ? d_addr_q  : (sel_fetch ? i_addr_q  : 32'h0);
    mem_wdata = sel_data ? d_wdata_q : (sel_fetch ? i_wdata_q : 32'h0);
    mem_wstrb = sel_data ? d_wstrb_q : (sel_fetch ? i_wstrb_q : 4'h0);
  end

  always_comb begin
    state_d = state_q;
`ifdef MEM_ARBITER_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          state_d = grant_data ? BUSY_D : BUSY_I;
`ifdef MEM_ARBITER_RR_EN
          last_data_d = grant_data;
`endif
        end
      end
      BUSY_I:  if (mem_ready) state_d = IDLE;
      BUSY_D:  if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A port may refill its pending slot in the very cycle its response is returned.
  always_comb begin
    i_pend_d  = i_pend_q & ~imem_ready;
    i_instr_d = i_instr_q;
    i_addr_d  = i_addr_q;
    i_wdata_d = i_wdata_q;
    i_wstrb_d = i_wstrb_q;
    if (imem_valid & (~i_pend_q | imem_ready)) begin
      i_pend_d  = 1'b1;
      i_instr_d = imem_instr;
      i_addr_d  = imem_addr;
      i_wdata_d = imem_wdata;
      i_wstrb_d = imem_wstrb;
    end
    d_pend_d  = d_pend_q & ~dmem_ready;
    d_instr_d = d_instr_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_wstrb_d = d_wstrb_q;
    if (dmem_valid & (~d_pend_q | dmem_ready)) begin
      d_pend_d  = 1'b1;
      d_instr_d = dmem_instr;
      d_addr_d  = dmem_addr;
      d_wdata_d = dmem_wdata;
      d_wstrb_d = dmem_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_pend_q    <= 1'b0;
      d_pend_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_pend_q    <= i_pend_d;
      d_pend_q    <= d_pend_d;
`ifdef MEM_ARBITER_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    i_instr_q <= i_instr_d;
    i_addr_q  <= i_addr_d;
    i_wdata_q <= i_wdata_d;
    i_wstrb_q <= i_wstrb_d;
    d_instr_q <= d_instr_d;
    d_addr_q  <= d_addr_d;
    d_wdata_q <= d_wdata_d;
    d_wstrb_q <= d_wstrb_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed scenarios plus random traffic).
// Honours MEM_ARBITER_RR_EN in its reference model when the design is built with it.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_valid = 0, imem_instr = 0;
  logic [31:0] imem_addr = 0, imem_wdata = 0;
  logic [3:0]  imem_wstrb = 0;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_valid = 0, dmem_instr = 0;
  logic [31:0] dmem_addr = 0, dmem_wdata = 0;
  logic [3:0]  dmem_wstrb = 0;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic quiet();
    imem_valid = 0; dmem_valid = 0; mem_ready = 0;
  endtask

  task automatic apply_reset();
    cyc();
    quiet();
    reset = 0;
    cyc();
    cyc();
    reset = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    cyc();
    mem_ready = 1; mem_rdata = 32'hCAFE0001;
    sample();
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== 70'h0) begin
      errors++; $display("FAIL reset_mem_bus: got v=%0b a=%h w=%h s=%h, want all 0", mem_valid, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if ({imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== 66'h0) begin
      errors++; $display("FAIL reset_ready: got ir=%0b dr=%0b, want 0 (stray mem_ready in IDLE)", imem_ready, dmem_ready);
    end
    quiet();
  endtask

  task automatic test_fetch_only();
    int dr_seen = 0;
    apply_reset();
    cyc();
    imem_valid = 1; imem_instr = 1; imem_addr = 32'h100; imem_wdata = 0; imem_wstrb = 0;
    sample();
    dr_seen += dmem_ready;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL fetch_c0_valid: got %0b want 0", mem_valid); end
    cyc();
    imem_valid = 0;
    sample();
    dr_seen += dmem_ready;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_instr !== 1'b1) begin
      errors++; $display("FAIL fetch_c1_issue: got v=%0b a=%h i=%0b want 1/100/1", mem_valid, mem_addr, mem_instr);
    end
    cyc();
    mem_ready = 1; mem_rdata = 32'h13;
    sample();
    dr_seen += dmem_ready;
    checks++;
    if (imem_ready !== 1'b1 || imem_rdata !== 32'h13 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_c2_resp: got r=%0b d=%h v=%0b want 1/13/0", imem_ready, imem_rdata, mem_valid);
    end
    cyc();
    mem_ready = 0;
    sample();
    dr_seen += dmem_ready;
    checks++;
    if (imem_ready !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_c3_idle: got r=%0b v=%0b want 0/0", imem_ready, mem_valid);
    end
    checks++;
    if (dr_seen != 0) begin errors++; $display("FAIL fetch_dmem_ready: got %0d pulses want 0", dr_seen); end
  endtask

  task automatic test_contention();
    bit last_data = 0;
    bit first_data;
    logic [31:0] fa, sa;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARBITER_RR_EN
      first_data = !last_data;
`else
      first_data = 1;
`endif
      fa = first_data ? 32'h8000 : 32'h200;
      sa = first_data ? 32'h200 : 32'h8000;
      cyc();
      imem_valid = 1; imem_instr = 1; imem_addr = 32'h200; imem_wdata = 0; imem_wstrb = 0;
      dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h8000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
      cyc();
      quiet();
      sample();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== fa) begin
        errors++; $display("FAIL contend_first r%0d: got v=%0b a=%h want 1/%h", r, mem_valid, mem_addr, fa);
      end
      if (first_data) begin
        checks++;
        if (mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'hF || mem_instr !== 1'b0) begin
          errors++; $display("FAIL contend_store r%0d: got w=%h s=%h i=%0b want deadbeef/f/0", r, mem_wdata, mem_wstrb, mem_instr);
        end
      end
      cyc();
      mem_ready = 1; mem_rdata = 32'h1000 + r;
      sample();
      checks++;
      if (dmem_ready !== first_data || imem_ready !== !first_data) begin
        errors++; $display("FAIL contend_resp1 r%0d: got dr=%0b ir=%0b want dr=%0b", r, dmem_ready, imem_ready, first_data);
      end
      cyc();
      mem_ready = 0;
      sample();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== sa) begin
        errors++; $display("FAIL contend_second r%0d: got v=%0b a=%h want 1/%h", r, mem_valid, mem_addr, sa);
      end
      cyc();
      mem_ready = 1;
      sample();
      checks++;
      if (dmem_ready !== !first_data || imem_ready !== first_data) begin
        errors++; $display("FAIL contend_resp2 r%0d: got dr=%0b ir=%0b want dr=%0b", r, dmem_ready, imem_ready, !first_data);
      end
      last_data = !first_data;
      cyc();
      mem_ready = 0;
    end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    logic [31:0] rd;
    apply_reset();
    cyc();
    dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h4000; dmem_wdata = 0; dmem_wstrb = 0;
    cyc();
    dmem_valid = 0;
    sample();
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h4000) begin
      errors++; $display("FAIL wait_issue: got v=%0b a=%h want 1/4000", mem_valid, mem_addr);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      sample();
      pulses += dmem_ready;
      checks++;
      if (mem_valid !== 1'b0 || mem_addr !== 32'h4000 || mem_wstrb !== 4'h0 || mem_instr !== 1'b0) begin
        errors++; $display("FAIL wait_hold w%0d: got v=%0b a=%h want 0/4000", k, mem_valid, mem_addr);
      end
    end
    rd = $urandom;
    cyc();
    mem_ready = 1; mem_rdata = rd;
    sample();
    pulses += dmem_ready;
    checks++;
    if (dmem_rdata !== rd) begin errors++; $display("FAIL wait_rdata: got %h want %h", dmem_rdata, rd); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      mem_ready = 0;
      sample();
      pulses += dmem_ready;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL wait_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_duplicate();
    int pulses = 0;
    int issues = 0;
    apply_reset();
    cyc();
    imem_valid = 1; imem_instr = 1; imem_addr = 32'h200;
    cyc();
    imem_addr = 32'h300;
    sample();
    issues += mem_valid;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL dup_issue: got v=%0b a=%h want 1/200", mem_valid, mem_addr);
    end
    cyc();
    imem_valid = 0; mem_ready = 1; mem_rdata = 32'h55;
    sample();
    pulses += imem_ready;
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_ready = 0;
      sample();
      pulses += imem_ready;
      issues += mem_valid;
    end
    checks++;
    if (pulses != 1 || issues != 1) begin
      errors++; $display("FAIL dup_count: got ready=%0d issues=%0d want 1/1", pulses, issues);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    apply_reset();
    cyc();
    dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h4000; dmem_wstrb = 0;
    cyc();
    dmem_valid = 0;
    cyc();
    cyc();
    reset = 0;
    cyc();
    reset = 1;
    cyc();
    mem_ready = 1; mem_rdata = 32'hBAD;
    sample();
    checks++;
    if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stray: got ir=%0b dr=%0b want 0/0", imem_ready, dmem_ready);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_ready = k[0];
      sample();
      stray += mem_valid + imem_ready + dmem_ready;
    end
    checks++;
    if (stray != 0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d events a=%h want 0/0", stray, mem_addr);
    end
  endtask

  // Reference model: pending requests per port, current bus owner, last granted port.
  task automatic test_random();
    bit pend[2];
    logic instr_m[2];
    logic [31:0] addr_m[2], wdata_m[2];
    logic [3:0] wstrb_m[2];
    int owner = -1;
    bit last_data = 0;
    int win;
    bit e_valid, rdy[2], vin[2];
    apply_reset();
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      cyc();
      imem_valid = ($urandom_range(0, 2) == 0); imem_instr = $urandom; imem_addr = $urandom;
      imem_wdata = $urandom; imem_wstrb = $urandom;
      dmem_valid = ($urandom_range(0, 2) == 0); dmem_instr = $urandom; dmem_addr = $urandom;
      dmem_wdata = $urandom; dmem_wstrb = $urandom;
      mem_ready = ($urandom_range(0, 4) < 2); mem_rdata = $urandom;
      sample();
      win = -1;
      if (owner < 0 && (pend[0] || pend[1])) begin
`ifdef MEM_ARBITER_RR_EN
        win = (pend[0] && pend[1]) ? (last_data ? 0 : 1) : (pend[1] ? 1 : 0);
`else
        win = pend[1] ? 1 : 0;
`endif
      end
      e_valid = (win >= 0);
      rdy[0] = (owner == 0) && mem_ready;
      rdy[1] = (owner == 1) && mem_ready;
      checks++;
      if (mem_valid !== e_valid || imem_ready !== rdy[0] || dmem_ready !== rdy[1]) begin
        errors++; $display("FAIL rand_ctrl n%0d: got v=%0b ir=%0b dr=%0b want %0b/%0b/%0b",
                           n, mem_valid, imem_ready, dmem_ready, e_valid, rdy[0], rdy[1]);
      end
      if (win >= 0 || owner >= 0) begin
        int p;
        p = (win >= 0) ? win : owner;
        checks++;
        if (mem_instr !== instr_m[p] || mem_addr !== addr_m[p] || mem_wdata !== wdata_m[p] || mem_wstrb !== wstrb_m[p]) begin
          errors++; $display("FAIL rand_fields n%0d: got a=%h w=%h s=%h want a=%h w=%h s=%h",
                             n, mem_addr, mem_wdata, mem_wstrb, addr_m[p], wdata_m[p], wstrb_m[p]);
        end
      end
      if (rdy[0] || rdy[1]) begin
        checks++;
        if ((rdy[0] && imem_rdata !== mem_rdata) || (rdy[1] && dmem_rdata !== mem_rdata)) begin
          errors++; $display("FAIL rand_rdata n%0d: got i=%h d=%h want %h", n, imem_rdata, dmem_rdata, mem_rdata);
        end
      end
      if (win >= 0) begin
        owner = win; last_data = (win == 1);
      end else if (owner >= 0 && mem_ready) begin
        pend[owner] = 0; owner = -1;
      end
      vin[0] = imem_valid; vin[1] = dmem_valid;
      for (int p = 0; p < 2; p++) begin
        if (vin[p] && (!pend[p] || rdy[p])) begin
          pend[p] = 1;
          instr_m[p] = p ? dmem_instr : imem_instr;
          addr_m[p]  = p ? dmem_addr  : imem_addr;
          wdata_m[p] = p ? dmem_wdata : imem_wdata;
          wstrb_m[p] = p ? dmem_wstrb : imem_wstrb;
        end
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_contention();
    test_wait_states();
    test_duplicate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
